// File: rtl/m9312_pkg.sv
// Shared definitions for the M9312 boot-vector sequencer and the
// Unibus slave responders that sit beside it (ROM window, cycle types).
package m9312_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_WAITPSW = 2'd2,
        ST_DONE    = 2'd3
    } bv_state_e;

    localparam logic [1:0] C_DATI  = 2'b00;
    localparam logic [1:0] C_DATIP = 2'b01;

    // Address bits 17:9 of the boot ROM window (765xxx).
    localparam logic [8:0] ROM_WINDOW = 9'o765;

    localparam int DEF_DELAY = 19;

endpackage

// File: rtl/m9312_bootvec_unibus_slave_hs.sv
// Unibus slave handshake: qualify MSYN, assert jam, count DELAY clocks,
// raise SSYN with latched data, hold until MSYN drops, then release.
// Ports: clk_i/rst_i, clr_i (sync abort), msyn_i, qual_i, data_i;
//        data_o, ssyn_o, jam_o, done_o (release pulse, comb).
module unibus_slave_hs #(
    parameter int DELAY = 19
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        msyn_i,
    input  logic        qual_i,
    input  logic [15:0] data_i,
    output logic [15:0] data_o,
    output logic        ssyn_o,
    output logic        jam_o,
    output logic        done_o
);

    localparam int CW = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam logic [CW-1:0] LAST = CW'(DELAY - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          jam_q, jam_d;
    logic          ssyn_q, ssyn_d;
    logic [15:0]   data_q, data_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            jam_q  <= 1'b0;
            ssyn_q <= 1'b0;
            data_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            jam_q  <= jam_d;
            ssyn_q <= ssyn_d;
            data_q <= data_d;
        end
    end

    // The jam clock is the first qualified sample; counting starts on
    // the one after it, so SSYN rises DELAY+1 clocks after that sample.
    always_comb begin
        cnt_d  = cnt_q;
        jam_d  = jam_q;
        ssyn_d = ssyn_q;
        data_d = data_q;
        done_o = 1'b0;
        if (clr_i) begin
            cnt_d  = '0;
            jam_d  = 1'b0;
            ssyn_d = 1'b0;
            data_d = '0;
        end else if (ssyn_q) begin
            // Hold phase: only MSYN matters, address may wander.
            if (!msyn_i) begin
                cnt_d  = '0;
                jam_d  = 1'b0;
                ssyn_d = 1'b0;
                data_d = '0;
                done_o = 1'b1;
            end
        end else if (jam_q) begin
            if (!qual_i) begin
                cnt_d = '0;
                jam_d = 1'b0;
            end else if (cnt_q == LAST) begin
                ssyn_d = 1'b1;
                data_d = data_i;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (qual_i) begin
            jam_d = 1'b1;
        end
    end

    assign data_o = data_q;
    assign ssyn_o = ssyn_q;
    assign jam_o  = jam_q;

endmodule

// File: rtl/m9312_bootvec.sv
// Power-up boot-vector sequencer: answers the first DATI pair to the
// power-fail vector with a ROM entry PC and a fixed PSW, then disarms.
// Ports: CLOCK/RESET, a_in_h, c_in_h, msyn_in_h, dc_lo_in_h, enable_h,
//        boot_sel in; d_out_h, ssyn_out_h, jam_out_h, armed_h out.
module m9312_bootvec
    import m9312_pkg::*;
#(
    parameter int          DELAY    = DEF_DELAY,
    parameter logic [17:0] VEC_ADDR = 18'o000024,
    parameter logic [15:0] ROM_BASE = 16'o165000,
    parameter logic [15:0] PSW_VAL  = 16'o000340
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [17:0] a_in_h,
    input  logic [1:0]  c_in_h,
    input  logic        msyn_in_h,
    input  logic        dc_lo_in_h,
    input  logic        enable_h,
    input  logic [7:0]  boot_sel,
    output logic [15:0] d_out_h,
    output logic        ssyn_out_h,
    output logic        jam_out_h,
    output logic        armed_h
);

    localparam logic [17:0] PSW_ADDR = VEC_ADDR + 18'd2;

    bv_state_e state_q, state_d;
    logic      dc_lo_q;
    logic      dc_lo_prev_q;
    logic      power_up;
    logic      read_cyc;
    logic      vec_hit;
    logic      psw_hit;
    logic      qual;
    logic [15:0] resp_data;
    logic      hs_done;
    logic      hs_hold;
    logic      unused_a0;

    assign unused_a0 = a_in_h[0];

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            dc_lo_q      <= 1'b0;
            dc_lo_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dc_lo_q      <= dc_lo_in_h;
            dc_lo_prev_q <= dc_lo_q;
        end
    end

    assign power_up = dc_lo_prev_q & ~dc_lo_q;

    // A registered DC LO aborts everything, so DONE needs no rule of
    // its own to return to IDLE on power-down.
    always_comb begin
        state_d = state_q;
        if (dc_lo_q) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (power_up && enable_h) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (hs_done)
                        state_d = enable_h ? ST_WAITPSW : ST_IDLE;
                    else if (!enable_h && !hs_hold)
                        state_d = ST_IDLE;
                end
                ST_WAITPSW: begin
                    if (hs_done)
                        state_d = enable_h ? ST_DONE : ST_IDLE;
                    else if (!enable_h && !hs_hold)
                        state_d = ST_IDLE;
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        read_cyc  = (c_in_h == C_DATI) || (c_in_h == C_DATIP);
        vec_hit   = a_in_h[17:1] == VEC_ADDR[17:1];
        psw_hit   = a_in_h[17:1] == PSW_ADDR[17:1];
        armed_h   = 1'b0;
        qual      = 1'b0;
        resp_data = '0;
        unique case (state_q)
            ST_ARMED: begin
                armed_h   = 1'b1;
                qual      = msyn_in_h & read_cyc & vec_hit & enable_h;
                resp_data = ROM_BASE | {7'b0, boot_sel, 1'b0};
            end
            ST_WAITPSW: begin
                armed_h   = 1'b1;
                qual      = msyn_in_h & read_cyc & psw_hit & enable_h;
                resp_data = PSW_VAL;
            end
            default: begin
                armed_h   = 1'b0;
            end
        endcase
    end

    unibus_slave_hs #(
        .DELAY (DELAY)
    ) u_hs (
        .clk_i  (CLOCK),
        .rst_i  (RESET),
        .clr_i  (dc_lo_q),
        .msyn_i (msyn_in_h),
        .qual_i (qual),
        .data_i (resp_data),
        .data_o (d_out_h),
        .ssyn_o (ssyn_out_h),
        .jam_o  (jam_out_h),
        .done_o (hs_done)
    );

    assign hs_hold = ssyn_out_h;

endmodule
